// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Holds the shift op encodings, the FSM state encodings and the datapath width.
package shift_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } sh_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One partial shift of the accumulator by k bits (k <= STEP), purely combinational.
// Ports: acc (current value), op (shift kind), k (bit count), res (shifted value).
module shift_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  logic [3:0]       k,
    output logic [WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        // Shifting a doubled copy right makes the LSB spill-out wrap into the MSB.
        dbl = {acc, acc} >> k;
        res = acc;
        unique case (sh_op_t'(op))
            SH_SLL:  res = acc << k;
            SH_SRL:  res = acc >> k;
            SH_SRA:  res = $unsigned($signed(acc) >>> k);
            SH_ROTR: res = dbl[WIDTH-1:0];
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA/ROTR by sa, at most STEP bits per clock.
// Ports: clk, rst (sync, active high), start/op/data_in/sa in; busy/done/result out.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int STEP = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       sa,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [4:0] STEP5 = 5'(STEP);
    localparam logic [3:0] STEP4 = 4'(STEP);

    state_t           state;
    state_t           state_n;
    sh_op_t           op_q;
    sh_op_t           op_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] result_n;
    logic [WIDTH-1:0] stepped;
    logic [4:0]       cnt;
    logic [4:0]       cnt_n;
    logic [3:0]       k;
    logic             last;

    // Remaining count fits in one step: take all of it and finish.
    assign last = (cnt <= STEP5);
    assign k    = last ? cnt[3:0] : STEP4;

    shift_step u_step (
        .acc (acc),
        .op  (op_q),
        .k   (k),
        .res (stepped)
    );

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        op_n     = op_q;
        result_n = result;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_n   = data_in;
                    cnt_n   = sa;
                    op_n    = sh_op_t'(op);
                    state_n = (sa == 5'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_n = stepped;
                cnt_n = cnt - {1'b0, k};
                if (last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Result is published on the edge that enters DONE, using the final acc.
        if (state_n == S_DONE) begin
            result_n = acc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= SH_SLL;
            result <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            result <= result_n;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with STEP=1 and STEP=4 instances.
// Both instances share stimulus; expectations come from an arithmetic reference.
module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  sa;
    logic        busy1;
    logic        done1;
    logic [31:0] res1;
    logic        busy4;
    logic        done4;
    logic [31:0] res4;

    int checks;
    int failures;
    logic [31:0] prev1;
    logic [31:0] prev4;

    shift_seq_ctrl #(.STEP(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .sa      (sa),
        .busy    (busy1),
        .done    (done1),
        .result  (res1)
    );

    shift_seq_ctrl #(.STEP(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .sa      (sa),
        .busy    (busy4),
        .done    (done4),
        .result  (res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] o,
                                              input logic [31:0] d,
                                              input int s);
        logic [31:0] r;
        case (o)
            2'd0: r = d << s;
            2'd1: r = d >> s;
            2'd2: r = 32'($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected busy/done at cycle i after E0 when start is held through edge hold.
    // Starts are accepted every (L+2) edges: L+1 busy cycles plus one IDLE cycle.
    task automatic expect_at(input int i, input int l, input int hold,
                             output logic b, output logic d);
        b = 1'b0;
        d = 1'b0;
        for (int a = 0; a <= hold; a += l + 2) begin
            if (i >= a && i <= a + l) b = 1'b1;
            if (i == a + l) d = 1'b1;
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input int hold);
        logic [31:0] exp;
        logic        eb;
        logic        ed;
        int          l1;
        int          l4;
        exp = ref_shift(o, d, int'(s));
        l1  = int'(s);
        l4  = (int'(s) + 3) / 4;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        data_in = d;
        sa      = s;
        @(posedge clk);
        for (int i = 0; i <= hold + 36; i++) begin
            @(negedge clk);
            expect_at(i, l1, hold, eb, ed);
            chk($sformatf("busy1 c%0d", i), {31'b0, busy1}, {31'b0, eb});
            chk($sformatf("done1 c%0d", i), {31'b0, done1}, {31'b0, ed});
            chk($sformatf("res1 c%0d", i), res1, (i >= l1) ? exp : prev1);
            expect_at(i, l4, hold, eb, ed);
            chk($sformatf("busy4 c%0d", i), {31'b0, busy4}, {31'b0, eb});
            chk($sformatf("done4 c%0d", i), {31'b0, done4}, {31'b0, ed});
            chk($sformatf("res4 c%0d", i), res4, (i >= l4) ? exp : prev4);
            if (i == hold) begin
                start = 1'b0;
                if (hold == 0) begin
                    op      = 2'($urandom);
                    data_in = $urandom;
                    sa      = 5'($urandom);
                end
            end
        end
        prev1 = exp;
        prev4 = exp;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [4:0]  rs;
        checks   = 0;
        failures = 0;
        prev1    = '0;
        prev4    = '0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'd0;
        data_in  = '0;
        sa       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy1", {31'b0, busy1}, 32'd0);
        chk("rst done1", {31'b0, done1}, 32'd0);
        chk("rst res1", res1, 32'd0);
        chk("rst busy4", {31'b0, busy4}, 32'd0);
        chk("rst done4", {31'b0, done4}, 32'd0);
        chk("rst res4", res4, 32'd0);
        rst = 1'b0;

        run(2'd0, 32'h0000_0001, 5'd4, 0);
        chk("sll1 lit", res1, 32'h0000_0010);

        run(2'd2, 32'h8000_0000, 5'd31, 0);
        chk("sra31 lit", res1, 32'hFFFF_FFFF);
        run(2'd1, 32'h8000_0000, 5'd31, 0);
        chk("srl31 lit", res1, 32'h0000_0001);

        run(2'd3, 32'hDEAD_BEEF, 5'd0, 0);
        chk("rotr0 lit", res1, 32'hDEAD_BEEF);

        run(2'd3, 32'h1234_5678, 5'd9, 0);
        chk("rotr9 lit4", res4, 32'h3C09_1A2B);

        run(2'd0, 32'h0000_0001, 5'd3, 6);
        chk("held lit", res1, 32'h0000_0008);

        @(negedge clk);
        start   = 1'b1;
        op      = 2'd1;
        data_in = 32'hF000_0000;
        sa      = 5'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst busy1", {31'b0, busy1}, 32'd0);
        chk("mid rst done1", {31'b0, done1}, 32'd0);
        chk("mid rst res1", res1, 32'd0);
        chk("mid rst busy4", {31'b0, busy4}, 32'd0);
        chk("mid rst done4", {31'b0, done4}, 32'd0);
        chk("mid rst res4", res4, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post rst done1 c%0d", i), {31'b0, done1}, 32'd0);
            chk($sformatf("post rst done4 c%0d", i), {31'b0, done4}, 32'd0);
        end
        prev1 = '0;
        prev4 = '0;
        run(2'd1, 32'hF000_0000, 5'd8, 0);
        chk("srl8 lit1", res1, 32'h00F0_0000);
        chk("srl8 lit4", res4, 32'h00F0_0000);

        for (int n = 0; n < 16; n++) begin
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run(ro, rd, rs, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
